oc8051_ifetch_queue: RTL and testbench

- Instruction prefetch queue between the combinational code ROM (cxrom) and the oc8051 decode stage.
- Drives a word fetch address to the ROM and captures the 32-bit word that comes back in the same cycle.
- Stores the fetched bytes in a circular byte queue.
- Presents up to three in-order opcode bytes to the core; the core pops 0-3 bytes per cycle.
- A PC load (jump, call, ret, interrupt) flushes the queue and redirects fetch.

---
 rtl/oc8051_ifetch_queue.sv | 173 +++++++++++++++++
 tb/tb_oc8051_ifetch_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/oc8051_ifetch_queue.sv
// oc8051_ifetch_queue: instruction prefetch byte queue between the
// combinational code ROM and the decode stage. Fetches 4 bytes per fill
// from fetch_addr (not necessarily word aligned), presents up to three
// in-order opcode bytes, and flushes/redirects on a PC load.
// Optional build macro: OC8051_IFETCH_STATS_EN adds stat_fill/stat_starve.
module oc8051_ifetch_queue #(
  parameter int QDEPTH = 8,
  parameter int QAW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_ld,
  input  logic [15:0] pc_new,
  output logic [15:0] cxrom_addr,
  input  logic [31:0] cxrom_data_in,
  input  logic [1:0]  op_pop,
  output logic [7:0]  op1,
  output logic [7:0]  op2,
  output logic [7:0]  op3,
  output logic [1:0]  op_cnt,
  output logic [15:0] op_pc,
  output logic        pop_err
`ifdef OC8051_IFETCH_STATS_EN
  ,
  output logic [31:0] stat_fill,
  output logic [31:0] stat_starve
`endif
);

  // A fill needs room for a whole ROM word, i.e. count <= QDEPTH-4.
  localparam logic [QAW:0] FILL_LIMIT = (QAW+1)'(QDEPTH - 4);
  localparam logic [QAW:0] CNT_THREE  = (QAW+1)'(3);
  localparam logic [QAW:0] CNT_FOUR   = (QAW+1)'(4);

  logic [15:0]    fetch_addr_r;
  logic [QAW-1:0] wr_ptr_r;
  logic [QAW-1:0] rd_ptr_r;
  logic [QAW:0]   count_r;
  logic [15:0]    op_pc_r;
  logic           pop_err_r;
  logic [7:0]     queue_r [QDEPTH];

  logic           fill_s;
  logic           pop_ok_s;
  logic           pop_bad_s;
  logic [1:0]     op_cnt_s;
  logic [QAW:0]   pop_amt_s;
  logic [QAW:0]   count_next_s;

  assign cxrom_addr = fetch_addr_r;
  assign op_pc      = op_pc_r;
  assign pop_err    = pop_err_r;
  assign op_cnt     = op_cnt_s;

  // Fill/pop decisions, all taken from registered state (not post-pop count).
  always_comb begin
    op_cnt_s     = 2'd0;
    fill_s       = 1'b0;
    pop_ok_s     = 1'b0;
    pop_bad_s    = 1'b0;
    pop_amt_s    = '0;
    count_next_s = count_r;
    if (count_r >= CNT_THREE) begin
      op_cnt_s = 2'd3;
    end else begin
      op_cnt_s = count_r[1:0];
    end
    if (pc_ld) begin
      fill_s    = 1'b0;
      pop_ok_s  = 1'b0;
      pop_bad_s = 1'b0;
    end else begin
      fill_s    = (count_r <= FILL_LIMIT);
      pop_ok_s  = (op_pop <= op_cnt_s);
      pop_bad_s = (op_pop > op_cnt_s);
    end
    if (pop_ok_s) begin
      pop_amt_s = {{(QAW-1){1'b0}}, op_pop};
    end else begin
      pop_amt_s = '0;
    end
    if (fill_s) begin
      count_next_s = count_r + CNT_FOUR - pop_amt_s;
    end else begin
      count_next_s = count_r - pop_amt_s;
    end
  end

  // Control state: reset beats PC load, which beats pop and fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_addr_r <= 16'h0000;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      op_pc_r      <= 16'h0000;
      pop_err_r    <= 1'b0;
    end else if (pc_ld) begin
      fetch_addr_r <= pc_new;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      op_pc_r      <= pc_new;
      pop_err_r    <= 1'b0;
    end else begin
      count_r   <= count_next_s;
      pop_err_r <= pop_bad_s;
      if (fill_s) begin
        fetch_addr_r <= fetch_addr_r + 16'd4;
        wr_ptr_r     <= wr_ptr_r + QAW'(4);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + pop_amt_s[QAW-1:0];
        op_pc_r  <= op_pc_r + {14'd0, op_pop};
      end
    end
  end

  // Byte storage: capture the ROM word at wr_ptr..wr_ptr+3; never reset.
  always_ff @(posedge clk) begin
    if (rst && fill_s) begin
      for (int i = 0; i < 4; i++) begin
        queue_r[wr_ptr_r + QAW'(i)] <= cxrom_data_in[8*i +: 8];
      end
    end
  end

  // Opcode byte presentation; bytes beyond op_cnt read as zero.
  always_comb begin
    op1 = 8'h00;
    op2 = 8'h00;
    op3 = 8'h00;
    if (op_cnt_s >= 2'd1) begin
      op1 = queue_r[rd_ptr_r];
    end else begin
      op1 = 8'h00;
    end
    if (op_cnt_s >= 2'd2) begin
      op2 = queue_r[rd_ptr_r + QAW'(1)];
    end else begin
      op2 = 8'h00;
    end
    if (op_cnt_s == 2'd3) begin
      op3 = queue_r[rd_ptr_r + QAW'(2)];
    end else begin
      op3 = 8'h00;
    end
  end

`ifdef OC8051_IFETCH_STATS_EN
  logic [31:0] stat_fill_r;
  logic [31:0] stat_starve_r;

  assign stat_fill   = stat_fill_r;
  assign stat_starve = stat_starve_r;

  // Statistics counters; cleared only by reset, free-running otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_fill_r   <= 32'd0;
      stat_starve_r <= 32'd0;
    end else begin
      if (fill_s) begin
        stat_fill_r <= stat_fill_r + 32'd1;
      end
      if ((op_cnt_s == 2'd0) && !pc_ld) begin
        stat_starve_r <= stat_starve_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_oc8051_ifetch_queue.sv
// Directed testbench for oc8051_ifetch_queue (QDEPTH=8).
// The ROM model returns the low byte of each byte address.
module tb_oc8051_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        pc_ld;
  logic [15:0] pc_new;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic [1:0]  op_pop;
  logic [7:0]  op1, op2, op3;
  logic [1:0]  op_cnt;
  logic [15:0] op_pc;
  logic        pop_err;
`ifdef OC8051_IFETCH_STATS_EN
  logic [31:0] stat_fill;
  logic [31:0] stat_starve;
`endif

  int errors;
  int checks;

  oc8051_ifetch_queue #(.QDEPTH(8), .QAW(3)) dut (
    .clk(clk), .rst(rst), .pc_ld(pc_ld), .pc_new(pc_new),
    .cxrom_addr(cxrom_addr), .cxrom_data_in(cxrom_data_in),
    .op_pop(op_pop), .op1(op1), .op2(op2), .op3(op3),
    .op_cnt(op_cnt), .op_pc(op_pc), .pop_err(pop_err)
`ifdef OC8051_IFETCH_STATS_EN
    , .stat_fill(stat_fill), .stat_starve(stat_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM: byte at address a holds a[7:0].
  always_comb begin
    logic [15:0] a1, a2, a3;
    a1 = cxrom_addr + 16'd1;
    a2 = cxrom_addr + 16'd2;
    a3 = cxrom_addr + 16'd3;
    cxrom_data_in = {a3[7:0], a2[7:0], a1[7:0], cxrom_addr[7:0]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_ld = 1'b0; pc_new = 16'h0000; op_pop = 2'd0;
    step(); step();
    checks++; if (cxrom_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", cxrom_addr); end
    checks++; if (op_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", op_cnt); end
    checks++; if ({op1, op2, op3} !== 24'h000000) begin errors++; $display("FAIL reset_ops got=%h exp=000000", {op1, op2, op3}); end
    checks++; if (op_pc !== 16'h0000 || pop_err !== 1'b0) begin errors++; $display("FAIL reset_pc got=%h/%b exp=0000/0", op_pc, pop_err); end
  endtask

  task automatic test_fill();
    rst = 1'b1;
    step();
    checks++; if (cxrom_addr !== 16'h0004) begin errors++; $display("FAIL fill1_addr got=%h exp=0004", cxrom_addr); end
    checks++; if (op_cnt !== 2'd3 || {op1, op2, op3} !== 24'h000102) begin errors++; $display("FAIL fill1_ops got=%0d/%h exp=3/000102", op_cnt, {op1, op2, op3}); end
    step();
    checks++; if (cxrom_addr !== 16'h0008) begin errors++; $display("FAIL fill2_addr got=%h exp=0008", cxrom_addr); end
    step();
    checks++; if (cxrom_addr !== 16'h0008) begin errors++; $display("FAIL fill_stall got=%h exp=0008", cxrom_addr); end
    checks++; if (op_pc !== 16'h0000 || {op1, op2, op3} !== 24'h000102) begin errors++; $display("FAIL fill_hold got=%h/%h exp=0000/000102", op_pc, {op1, op2, op3}); end
  endtask

  // Pops of 3 whenever three bytes are presented; small model of count/pc/fetch.
  task automatic test_steady_pop();
    int          m_count;
    logic [15:0] m_pc, m_fetch, b1, b2;
    logic [1:0]  m_cnt;
    int          p;
    m_count = 8; m_pc = 16'h0000; m_fetch = 16'h0008;
    for (int i = 0; i < 12; i++) begin
      p = (m_count >= 3) ? 3 : 0;
      op_pop = 2'(p);
      if (m_count <= 4) begin
        m_count = m_count + 4;
        m_fetch = m_fetch + 16'd4;
      end
      m_count = m_count - p;
      m_pc = m_pc + 16'(p);
      step();
      m_cnt = (m_count >= 3) ? 2'd3 : 2'(m_count);
      b1 = m_pc + 16'd1; b2 = m_pc + 16'd2;
      checks++; if (op_pc !== m_pc || op_cnt !== m_cnt) begin errors++; $display("FAIL steady_pc[%0d] got=%h/%0d exp=%h/%0d", i, op_pc, op_cnt, m_pc, m_cnt); end
      checks++; if (cxrom_addr !== m_fetch || pop_err !== 1'b0) begin errors++; $display("FAIL steady_fetch[%0d] got=%h/%b exp=%h/0", i, cxrom_addr, pop_err, m_fetch); end
      if (m_cnt == 2'd3) begin
        checks++; if ({op1, op2, op3} !== {m_pc[7:0], b1[7:0], b2[7:0]}) begin errors++; $display("FAIL steady_ops[%0d] got=%h exp=%h", i, {op1, op2, op3}, {m_pc[7:0], b1[7:0], b2[7:0]}); end
      end
    end
    op_pop = 2'd0;
  endtask

  task automatic test_pc_ld();
    op_pop = 2'd0;
    step(); step(); step();
    pc_ld = 1'b1; pc_new = 16'h1235; op_pop = 2'd2;
    step();
    pc_ld = 1'b0; op_pop = 2'd0;
    checks++; if (op_cnt !== 2'd0 || op1 !== 8'h00) begin errors++; $display("FAIL ld_flush got=%0d/%h exp=0/00", op_cnt, op1); end
    checks++; if (op_pc !== 16'h1235 || cxrom_addr !== 16'h1235) begin errors++; $display("FAIL ld_redirect got=%h/%h exp=1235/1235", op_pc, cxrom_addr); end
    step();
    checks++; if (op_cnt !== 2'd3 || {op1, op2, op3} !== 24'h353637) begin errors++; $display("FAIL ld_first got=%0d/%h exp=3/353637", op_cnt, {op1, op2, op3}); end
    checks++; if (cxrom_addr !== 16'h1239 || op_pc !== 16'h1235) begin errors++; $display("FAIL ld_next got=%h/%h exp=1239/1235", cxrom_addr, op_pc); end
  endtask

  task automatic test_wrap();
    pc_ld = 1'b1; pc_new = 16'hFFFD;
    step();
    pc_ld = 1'b0;
    checks++; if (cxrom_addr !== 16'hFFFD) begin errors++; $display("FAIL wrap_addr0 got=%h exp=FFFD", cxrom_addr); end
    step();
    checks++; if (cxrom_addr !== 16'h0001 || op_pc !== 16'hFFFD || {op1, op2, op3} !== 24'hFDFEFF) begin errors++; $display("FAIL wrap_fill got=%h/%h/%h exp=0001/FFFD/FDFEFF", cxrom_addr, op_pc, {op1, op2, op3}); end
    op_pop = 2'd1;
    step();
    checks++; if (op_pc !== 16'hFFFE || {op1, op2, op3} !== 24'hFEFF00) begin errors++; $display("FAIL wrap_pc1 got=%h/%h exp=FFFE/FEFF00", op_pc, {op1, op2, op3}); end
    step();
    checks++; if (op_pc !== 16'hFFFF || {op1, op2, op3} !== 24'hFF0001) begin errors++; $display("FAIL wrap_pc2 got=%h/%h exp=FFFF/FF0001", op_pc, {op1, op2, op3}); end
    step();
    checks++; if (op_pc !== 16'h0000 || {op1, op2, op3} !== 24'h000102) begin errors++; $display("FAIL wrap_pc3 got=%h/%h exp=0000/000102", op_pc, {op1, op2, op3}); end
    op_pop = 2'd0;
  endtask

  task automatic test_pop_err();
    pc_ld = 1'b1; pc_new = 16'h0040;
    step();
    pc_ld = 1'b0; op_pop = 2'd3;
    step();
    op_pop = 2'd0;
    checks++; if (pop_err !== 1'b1 || op_pc !== 16'h0040) begin errors++; $display("FAIL err_empty got=%b/%h exp=1/0040", pop_err, op_pc); end
    checks++; if (op_cnt !== 2'd3 || op1 !== 8'h40) begin errors++; $display("FAIL err_fill got=%0d/%h exp=3/40", op_cnt, op1); end
    step();
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL err_pulse got=%b exp=0", pop_err); end
    op_pop = 2'd3;
    step(); step();
    checks++; if (op_cnt !== 2'd2 || op_pc !== 16'h0046) begin errors++; $display("FAIL err_two got=%0d/%h exp=2/0046", op_cnt, op_pc); end
    step();
    op_pop = 2'd0;
    checks++; if (pop_err !== 1'b1 || op_pc !== 16'h0046 || op1 !== 8'h46 || op_cnt !== 2'd3) begin errors++; $display("FAIL err_over got=%b/%h/%h/%0d exp=1/0046/46/3", pop_err, op_pc, op1, op_cnt); end
    step();
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", pop_err); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0; pc_ld = 1'b1; pc_new = 16'h5555; op_pop = 2'd1;
    step();
    checks++; if (cxrom_addr !== 16'h0000 || op_pc !== 16'h0000 || op_cnt !== 2'd0) begin errors++; $display("FAIL midrst got=%h/%h/%0d exp=0000/0000/0", cxrom_addr, op_pc, op_cnt); end
    rst = 1'b1; pc_ld = 1'b0; op_pop = 2'd0;
  endtask

`ifdef OC8051_IFETCH_STATS_EN
  task automatic test_stats();
    rst = 1'b0; pc_ld = 1'b0; op_pop = 2'd0;
    step();
    rst = 1'b1; pc_ld = 1'b1; pc_new = 16'h0100;
    step();
    pc_ld = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++; if (stat_fill !== 32'd2 || stat_starve !== 32'd1) begin errors++; $display("FAIL stats got=%0d/%0d exp=2/1", stat_fill, stat_starve); end
  endtask
`endif

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_fill();
    test_steady_pop();
    test_pc_ld();
    test_wrap();
    test_pop_err();
    test_reset_mid();
`ifdef OC8051_IFETCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
